// File: rtl/wb_pkg.sv
// Shared constants for the writeback buffer: register index width, data width
// and the default number of pending-write entries.
package wb_pkg;

   localparam int REG_ADDR_W    = 5;
   localparam int XLEN          = 32;
   localparam int DEFAULT_DEPTH = 4;

   typedef logic [REG_ADDR_W-1:0] regAddr_t;

endpackage

// File: rtl/writeback_buffer_if.sv
// Producer-to-buffer result handshake: the producer offers a destination index
// plus value, and the buffer answers with ready.
interface writeback_buffer_if
   import wb_pkg::*;
#(
   parameter int XLEN = wb_pkg::XLEN
);

   logic            wb_valid_i;
   logic            wb_ready_o;
   regAddr_t        wb_addr_i;
   logic [XLEN-1:0] wb_data_i;

   modport master (
      output wb_valid_i,
      output wb_addr_i,
      output wb_data_i,
      input  wb_ready_o
   );

   modport slave (
      input  wb_valid_i,
      input  wb_addr_i,
      input  wb_data_i,
      output wb_ready_o
   );

endinterface

// File: rtl/wb_match.sv
// Youngest-match search over the pending entries for one read port. Walking
// from head (oldest) to tail lets later hits override earlier ones.
module wb_match
   import wb_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int XLEN  = wb_pkg::XLEN
) (
   input  regAddr_t                          rsAddr_i,
   input  logic [DEPTH-1:0][REG_ADDR_W-1:0] entryAddr_i,
   input  logic [DEPTH-1:0][XLEN-1:0]       entryData_i,
   input  logic [DEPTH-1:0]                 occupied_i,
   input  logic [$clog2(DEPTH)-1:0]         head_i,
   output logic                             hit_o,
   output logic [XLEN-1:0]                  data_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] idx;

   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_i + PW'(k);
         if ((rsAddr_i != '0) && occupied_i[idx] && (entryAddr_i[idx] == rsAddr_i)) begin
            hit_o  = 1'b1;
            data_o = entryData_i[idx];
         end
      end
   end

endmodule

// File: rtl/writeback_buffer.sv
// Small FIFO of pending register-file writes with read-port forwarding, so
// results can retire whenever the register-file write port is granted.
module writeback_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int XLEN  = wb_pkg::XLEN
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   writeback_buffer_if.slave        wb,
   input  logic                     wr_grant_i,
   output regAddr_t                 RDaddr_o,
   output logic [XLEN-1:0]          RDdata_o,
   output logic                     RegWrite_o,
   input  regAddr_t                 RS1addr_i,
   input  regAddr_t                 RS2addr_i,
   input  logic [XLEN-1:0]          RS1data_i,
   input  logic [XLEN-1:0]          RS2data_i,
   output logic [XLEN-1:0]          RS1data_o,
   output logic [XLEN-1:0]          RS2data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q;
   logic [DEPTH-1:0][XLEN-1:0]       data_q;
   logic [PW-1:0]                    wrPtr_q, wrPtr_d;
   logic [PW-1:0]                    rdPtr_q, rdPtr_d;
   logic [CW-1:0]                    count_q, count_d;
   logic [DEPTH-1:0]                 occupied;
   logic                             push, pop, notEmpty;
   logic                             rs1Hit, rs2Hit;
   logic [XLEN-1:0]                  rs1Fwd, rs2Fwd;

   // Ready depends only on occupancy, so a full buffer refuses even while popping.
   assign notEmpty      = (count_q != '0);
   assign wb.wb_ready_o = rst_i && (count_q < FULL);
   assign push          = wb.wb_valid_i && wb.wb_ready_o && (wb.wb_addr_i != '0);
   assign RegWrite_o    = notEmpty && wr_grant_i;
   assign pop           = RegWrite_o;
   assign RDaddr_o      = notEmpty ? addr_q[rdPtr_q] : '0;
   assign RDdata_o      = notEmpty ? data_q[rdPtr_q] : '0;
   assign count_o       = count_q;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) wrPtr_d = wrPtr_q + 1'b1;
      if (pop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; validity comes from the pointers and count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[wrPtr_q] <= wb.wb_addr_i;
         data_q[wrPtr_q] <= wb.wb_data_i;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         occupied[i] = ({1'b0, PW'(i) - rdPtr_q} < count_q);
   end

   wb_match #(.DEPTH(DEPTH), .XLEN(XLEN)) rs1Match (
      .rsAddr_i    (RS1addr_i),
      .entryAddr_i (addr_q),
      .entryData_i (data_q),
      .occupied_i  (occupied),
      .head_i      (rdPtr_q),
      .hit_o       (rs1Hit),
      .data_o      (rs1Fwd)
   );

   wb_match #(.DEPTH(DEPTH), .XLEN(XLEN)) rs2Match (
      .rsAddr_i    (RS2addr_i),
      .entryAddr_i (addr_q),
      .entryData_i (data_q),
      .occupied_i  (occupied),
      .head_i      (rdPtr_q),
      .hit_o       (rs2Hit),
      .data_o      (rs2Fwd)
   );

   assign RS1data_o = rs1Hit ? rs1Fwd : RS1data_i;
   assign RS2data_o = rs2Hit ? rs2Fwd : RS2data_i;

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed self-checking bench for writeback_buffer: reset, retire latency,
// full stall, zero-address discard, forwarding, mid-run reset and pointer wrap.
module tb_writeback_buffer;
   import wb_pkg::*;

   localparam int DEPTH = 4;
   localparam int XW    = 32;

   logic            clk = 1'b0;
   logic            rstN;
   logic            wrGrant;
   logic [4:0]      rs1Addr, rs2Addr, rdAddr;
   logic [XW-1:0]   rs1DataIn, rs2DataIn, rs1DataOut, rs2DataOut, rdData;
   logic            regWrite;
   logic [2:0]      count;
   int              vectorCount = 0;
   int              miscompareCount = 0;
   logic [36:0]     expQ[$];
   logic [4:0]      drainAddr[4];
   logic [31:0]     drainData[4];

   always #5 clk = ~clk;

   writeback_buffer_if #(.XLEN(XW)) wbIf();

   writeback_buffer #(.DEPTH(DEPTH), .XLEN(XW)) dut (
      .clk_i      (clk),
      .rst_i      (rstN),
      .wb         (wbIf),
      .wr_grant_i (wrGrant),
      .RDaddr_o   (rdAddr),
      .RDdata_o   (rdData),
      .RegWrite_o (regWrite),
      .RS1addr_i  (rs1Addr),
      .RS2addr_i  (rs2Addr),
      .RS1data_i  (rs1DataIn),
      .RS2data_i  (rs2DataIn),
      .RS1data_o  (rs1DataOut),
      .RS2data_o  (rs2DataOut),
      .count_o    (count)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [4:0] addr, input logic [31:0] data, input logic grant);
      wbIf.wb_valid_i = valid;
      wbIf.wb_addr_i  = addr;
      wbIf.wb_data_i  = data;
      wrGrant         = grant;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN      = 1'b0;
      rs1Addr   = 5'd7;
      rs2Addr   = 5'd0;
      rs1DataIn = 32'hAAAA;
      rs2DataIn = 32'h5555;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      #1;
      checkOutput("rst_count",    64'(count),      64'h0);
      checkOutput("rst_ready",    64'(wbIf.wb_ready_o), 64'h0);
      checkOutput("rst_regwrite", 64'(regWrite),   64'h0);
      checkOutput("rst_rdaddr",   64'(rdAddr),     64'h0);
      checkOutput("rst_rddata",   64'(rdData),     64'h0);
      checkOutput("rst_rs1",      64'(rs1DataOut), 64'hAAAA);
      tick();
      rstN = 1'b1;
      #1;
      checkOutput("post_rst_ready", 64'(wbIf.wb_ready_o), 64'h1);

      // Single push retires in the following cycle.
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
      checkOutput("push_ready",    64'(wbIf.wb_ready_o), 64'h1);
      checkOutput("push_regwrite", 64'(regWrite), 64'h0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      checkOutput("lat_regwrite", 64'(regWrite), 64'h1);
      checkOutput("lat_rdaddr",   64'(rdAddr),   64'h5);
      checkOutput("lat_rddata",   64'(rdData),   64'hDEADBEEF);
      checkOutput("lat_count",    64'(count),    64'h1);
      tick();
      checkOutput("drained_count",    64'(count),    64'h0);
      checkOutput("drained_regwrite", 64'(regWrite), 64'h0);

      // Fill, stall a fifth offer, then accept it once an entry frees.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 32'(32'h100 + i), 1'b0);
         tick();
      end
      applyStimulus(1'b1, 5'd9, 32'h999, 1'b0);
      checkOutput("full_count", 64'(count), 64'h4);
      checkOutput("full_ready", 64'(wbIf.wb_ready_o), 64'h0);
      tick();
      checkOutput("stall_count", 64'(count), 64'h4);
      applyStimulus(1'b1, 5'd9, 32'h999, 1'b1);
      checkOutput("full_pop_ready", 64'(wbIf.wb_ready_o), 64'h0);
      checkOutput("full_pop_we",    64'(regWrite), 64'h1);
      checkOutput("full_pop_addr",  64'(rdAddr),   64'h1);
      tick();
      checkOutput("freed_count", 64'(count), 64'h3);
      checkOutput("freed_ready", 64'(wbIf.wb_ready_o), 64'h1);
      applyStimulus(1'b1, 5'd9, 32'h999, 1'b0);
      tick();
      checkOutput("fifth_count", 64'(count), 64'h4);
      drainAddr = '{5'd2, 5'd3, 5'd4, 5'd9};
      drainData = '{32'h101, 32'h102, 32'h103, 32'h999};
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("drain_we",   64'(regWrite), 64'h1);
         checkOutput("drain_addr", 64'(rdAddr),   64'(drainAddr[i]));
         checkOutput("drain_data", 64'(rdData),   64'(drainData[i]));
         tick();
      end
      checkOutput("drain_count", 64'(count), 64'h0);

      // Zero-address result handshakes but is dropped.
      applyStimulus(1'b1, 5'd0, 32'h1234, 1'b1);
      checkOutput("zero_ready", 64'(wbIf.wb_ready_o), 64'h1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      checkOutput("zero_count",    64'(count),    64'h0);
      checkOutput("zero_regwrite", 64'(regWrite), 64'h0);

      // Forwarding picks the youngest match and ignores the in-flight offer.
      rs1Addr   = 5'd3;
      rs1DataIn = 32'hFF;
      rs2Addr   = 5'd3;
      rs2DataIn = 32'hEE;
      applyStimulus(1'b1, 5'd3, 32'h11, 1'b0);
      checkOutput("fwd_none", 64'(rs1DataOut), 64'hFF);
      tick();
      applyStimulus(1'b1, 5'd3, 32'h22, 1'b0);
      checkOutput("fwd_old_only", 64'(rs1DataOut), 64'h11);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0);
      checkOutput("fwd_rs1_young", 64'(rs1DataOut), 64'h22);
      checkOutput("fwd_rs2_young", 64'(rs2DataOut), 64'h22);
      checkOutput("fwd_count",     64'(count),      64'h2);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      checkOutput("fwd_while_pop", 64'(rs1DataOut), 64'h22);
      tick();
      checkOutput("fwd_head_write", 64'(rs1DataOut), 64'h22);
      checkOutput("fwd_head_addr",  64'(rdAddr),     64'h3);
      tick();
      checkOutput("fwd_raw", 64'(rs1DataOut), 64'hFF);
      rs1Addr = 5'd0;
      rs2Addr = 5'd0;

      // Reset mid-operation drops pending entries immediately.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b0);
         tick();
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      checkOutput("pre_rst_count", 64'(count),    64'h3);
      checkOutput("pre_rst_we",    64'(regWrite), 64'h1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("async_rst_count", 64'(count),    64'h0);
      checkOutput("async_rst_we",    64'(regWrite), 64'h0);
      checkOutput("async_rst_addr",  64'(rdAddr),   64'h0);
      checkOutput("async_rst_ready", 64'(wbIf.wb_ready_o), 64'h0);
      tick();
      rstN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checkOutput("post_rst_we",    64'(regWrite), 64'h0);
         checkOutput("post_rst_count", 64'(count),    64'h0);
         tick();
      end

      // Back-to-back push/pop through several pointer wraps.
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b1, 5'(k + 1), 32'(32'hA000_0000 + k), (k >= 2));
         checkOutput("wrap_count", 64'(count), 64'(expQ.size()));
         if (k >= 2) begin
            checkOutput("wrap_we",   64'(regWrite), 64'h1);
            checkOutput("wrap_addr", 64'(rdAddr),   64'(expQ[0][36:32]));
            checkOutput("wrap_data", 64'(rdData),   64'(expQ[0][31:0]));
         end
         tick();
         if (k >= 2) void'(expQ.pop_front());
         expQ.push_back({5'(k + 1), 32'(32'hA000_0000 + k)});
      end
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1);
      for (int n = 0; n < 16 && expQ.size() > 0; n++) begin
         checkOutput("tail_we",   64'(regWrite), 64'h1);
         checkOutput("tail_addr", 64'(rdAddr),   64'(expQ[0][36:32]));
         checkOutput("tail_data", 64'(rdData),   64'(expQ[0][31:0]));
         tick();
         void'(expQ.pop_front());
      end
      checkOutput("tail_count",    64'(count),    64'h0);
      checkOutput("tail_regwrite", 64'(regWrite), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
